// File: rtl/id_ex_skid_stage.sv
// Decode->execute pipeline register with a two-entry (main + skid) buffer,
// load-use bubble insertion, flush and saturating stall/bubble counters.
module id_ex_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_W-1:0]  in_regA,
    input  logic [REG_W-1:0]  in_regB,
    input  logic              in_use_rb,
    input  logic              haz_mem_r_en,
    input  logic [REG_W-1:0]  haz_regD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

    logic hazard;
    logic accept;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; in_ready depends only on local state and the hazard inputs,
    // never on out_ready, and held entries stay stable until consumed.
    always_comb begin
        hazard = in_valid & haz_mem_r_en & (haz_regD != '0) &
                 ((haz_regD == in_regA) | (in_use_rb & (haz_regD == in_regB)));
        in_ready  = ~reset & (state_q != ST_FULL) & ~hazard;
        accept    = in_valid & in_ready;
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_data_q;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        stall_cnt  = stall_cnt_q;
        bubble_cnt = bubble_cnt_q;
        dbg_state  = state_q;
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (accept) begin
                    state_d     = ST_FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A taken branch kills everything held, including this cycle's input.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_ONE;

        bubble_cnt_d = bubble_cnt_q;
        if (hazard && bubble_cnt_q != CNT_MAX)
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed + random bench for id_ex_skid_stage: a FIFO reference model with
// expected-entry queue, hazard model and saturating counter models.
module tb_id_ex_skid_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [REG_W-1:0]  in_regA;
    logic [REG_W-1:0]  in_regB;
    logic              in_use_rb;
    logic              haz_mem_r_en;
    logic [REG_W-1:0]  haz_regD;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [1:0]        dbg_state;

    logic              in_ready2;
    logic              out_valid2;
    logic [DATA_W-1:0] out_data2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [1:0]        stall_cnt2;
    logic [1:0]        bubble_cnt2;
    logic [1:0]        dbg_state2;

    id_ex_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_regA(in_regA), .in_regB(in_regB), .in_use_rb(in_use_rb),
        .haz_mem_r_en(haz_mem_r_en), .haz_regD(haz_regD),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
    );

    // Narrow-counter copy driven by the same stimulus, for saturation.
    id_ex_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_regA(in_regA), .in_regB(in_regB), .in_use_rb(in_use_rb),
        .haz_mem_r_en(haz_mem_r_en), .haz_regD(haz_regD),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [DATA_W+CTRL_W-1:0] exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  stall_m = 0;
    int  bubble_m = 0;
    int  stall2_m = 0;
    int  bubble2_m = 0;
    bit  zero_m = 1'b1;
    int  sat16 = (1 << CNT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model, return just after posedge.
    task automatic cycle();
        bit haz;
        bit acc;
        logic [DATA_W+CTRL_W-1:0] head;
        @(negedge clk);
        haz = in_valid && haz_mem_r_en && (haz_regD != 0) &&
              ((haz_regD == in_regA) || (in_use_rb && (haz_regD == in_regB)));
        chk("in_ready", 64'(in_ready), 64'(!reset && exp_q.size() < 2 && !haz));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("occupancy", 64'(dbg_state), 64'(exp_q.size()));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("out_data", 64'(out_data), 64'(head[DATA_W+CTRL_W-1:CTRL_W]));
            chk("out_ctrl", 64'(out_ctrl), 64'(head[CTRL_W-1:0]));
        end else begin
            chk("out_ctrl_idle", 64'(out_ctrl), 64'd0);
            if (zero_m) chk("out_data_zero", 64'(out_data), 64'd0);
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
        chk("stall_cnt_w2", 64'(stall_cnt2), 64'(stall2_m));
        chk("bubble_cnt_w2", 64'(bubble_cnt2), 64'(bubble2_m));

        if (reset) begin
            exp_q.delete();
            stall_m = 0; bubble_m = 0; stall2_m = 0; bubble2_m = 0;
            zero_m = 1'b1;
        end else begin
            if (exp_q.size() > 0 && !out_ready) begin
                if (stall_m < sat16) stall_m++;
                if (stall2_m < 3) stall2_m++;
            end
            if (haz) begin
                if (bubble_m < sat16) bubble_m++;
                if (bubble2_m < 3) bubble2_m++;
            end
            if (flush) begin
                exp_q.delete();
                zero_m = 1'b1;
            end else begin
                acc = in_valid && exp_q.size() < 2 && !haz;
                if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (acc) begin
                    exp_q.push_back({in_data, in_ctrl});
                    zero_m = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic drive_in(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = CTRL_W'($urandom_range(1, 16'hFFFF));
    endtask

    task automatic set_haz(input logic en, input logic [REG_W-1:0] rd,
                           input logic [REG_W-1:0] ra, input logic [REG_W-1:0] rb,
                           input logic use_rb);
        haz_mem_r_en = en;
        haz_regD     = rd;
        in_regA      = ra;
        in_regB      = rb;
        in_use_rb    = use_rb;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_in(1'b0, '0);
        set_haz(1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
        cycle(); cycle();
        reset = 1'b0;
        cycle();

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive_in(1'b1, DATA_W'(i));
            cycle();
        end
        drive_in(1'b0, '0);
        cycle(); cycle();

        // back-pressure: fill, attempt a third push, hold, then drain
        out_ready = 1'b0;
        drive_in(1'b1, 32'hAAAA_0001); cycle();
        drive_in(1'b1, 32'hBBBB_0002); cycle();
        drive_in(1'b1, 32'hCCCC_0003); cycle();
        cycle();
        drive_in(1'b0, '0);
        cycle();
        out_ready = 1'b1;
        cycle(); cycle(); cycle(); cycle();

        // load-use: main consumed while the hazard blocks the next instruction
        drive_in(1'b1, 32'h0000_0D01);
        cycle();
        set_haz(1'b1, 5'd5, 5'd5, 5'd2, 1'b0);
        drive_in(1'b1, 32'h0000_0D02);
        cycle();
        set_haz(1'b0, 5'd5, 5'd5, 5'd2, 1'b0);
        cycle();
        drive_in(1'b0, '0);
        cycle();
        set_haz(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        drive_in(1'b1, 32'h0000_0D03);
        cycle();
        drive_in(1'b0, '0);
        cycle();

        // regB match only counts when the instruction reads regB
        set_haz(1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
        drive_in(1'b1, 32'h0000_0E01);
        cycle();
        set_haz(1'b1, 5'd7, 5'd1, 5'd7, 1'b1);
        drive_in(1'b1, 32'h0000_0E02);
        cycle();
        set_haz(1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
        cycle();
        drive_in(1'b0, '0);
        cycle(); cycle();

        // flush while FULL with a valid input
        out_ready = 1'b0;
        drive_in(1'b1, 32'hF000_0001); cycle();
        drive_in(1'b1, 32'hF000_0002); cycle();
        flush = 1'b1;
        drive_in(1'b1, 32'hF000_0003); cycle();
        flush = 1'b0;
        drive_in(1'b0, '0);
        out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // reset in the middle of FULL
        out_ready = 1'b0;
        drive_in(1'b1, 32'h5EED_0001); cycle();
        drive_in(1'b1, 32'h5EED_0002); cycle();
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive_in(1'b0, '0);
        cycle();

        // random traffic; narrow counters saturate along the way
        for (int i = 0; i < 120; i++) begin
            drive_in(1'($urandom_range(0, 1)), DATA_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            set_haz(($urandom_range(0, 2) == 0), REG_W'($urandom_range(0, 3)),
                    REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            cycle();
        end
        flush = 1'b0;
        drive_in(1'b0, '0);
        set_haz(1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
        out_ready = 1'b0;
        drive_in(1'b1, 32'h0000_5A70); cycle();
        drive_in(1'b0, '0);
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1'b1;
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
